// File: rtl/mem_stage.sv
// Memory stage: data-memory request/response handshakes and load alignment.
// Define MEM_STALL_CNT_EN to add the load/store stall-cycle counter ports.
module mem_stage #(
  parameter int EX_BUS_WD = 107,
  parameter int WB_BUS_WD = 70
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0]          load_stall_cnt,
  output logic [31:0]          store_stall_cnt,
`endif
  input  logic                 ex_to_mem_valid,
  input  logic [EX_BUS_WD-1:0] ex_to_mem_bus,
  output logic                 mem_allow_in,
  output logic                 mem_to_wb_valid,
  output logic [WB_BUS_WD-1:0] mem_to_wb_bus,
  input  logic                 wb_allow_in,
  output logic [38:0]          mem_read_after_write_bus,
  output logic                 data_req_valid,
  input  logic                 data_req_ready,
  output logic [31:0]          data_addr,
  output logic                 data_wen,
  output logic [3:0]           data_wstrb,
  output logic [31:0]          data_wdata,
  input  logic [31:0]          data_rdata,
  input  logic                 data_rdata_valid,
  output logic                 data_rdata_ready
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic                 mem_valid;
  logic [EX_BUS_WD-1:0] ex_r;
  logic                 mem_ready_go;
  logic [31:0]          load_data_r;
  logic [31:0]          load_fmt;
  logic [31:0]          rf_wdata;

  logic [31:0] pc;
  logic        rf_write;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic [1:0]  off;
  logic        is_mem;

  assign pc         = ex_r[106:75];
  assign rf_write   = ex_r[74];
  assign rf_waddr   = ex_r[73:69];
  assign alu_result = ex_r[68:37];
  assign mem_read   = ex_r[36];
  assign mem_write  = ex_r[35];
  assign funct3     = ex_r[34:32];
  assign store_data = ex_r[31:0];
  assign off        = alu_result[1:0];
  assign is_mem     = mem_read | mem_write;

  assign mem_allow_in    = !mem_valid || (mem_ready_go && wb_allow_in);
  assign mem_to_wb_valid = mem_valid && mem_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
    end else if (mem_allow_in) begin
      mem_valid <= ex_to_mem_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ex_to_mem_valid && mem_allow_in) begin
      ex_r <= ex_to_mem_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    data_req_valid   = 1'b0;
    data_rdata_ready = 1'b0;
    mem_ready_go     = !is_mem;
    unique case (state)
      IDLE: begin
        data_req_valid = mem_valid && is_mem;
        if (data_req_valid && data_req_ready) begin
          state_nx = mem_write ? HOLD : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        data_rdata_ready = 1'b1;
        if (data_rdata_valid) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        mem_ready_go = 1'b1;
        if (wb_allow_in) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request fields derive only from the held instruction, so they stay stable
  assign data_addr = {alu_result[31:2], 2'b00};
  assign data_wen  = mem_write;

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = store_data;
    unique case (funct3)
      3'b000: begin
        data_wstrb = 4'b0001 << off;
        data_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        data_wstrb = 4'b0011 << {off[1], 1'b0};
        data_wdata = {2{store_data[15:0]}};
      end
      default: data_wstrb = 4'b1111;
    endcase
    if (!mem_write) begin
      data_wstrb = 4'b0000;
    end
  end

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = 8'(data_rdata >> {off, 3'b000});
  assign rhalf = off[1] ? data_rdata[31:16] : data_rdata[15:0];

  always_comb begin
    load_fmt = data_rdata;
    unique case (funct3)
      3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_fmt = {24'd0, rbyte};
      3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_fmt = {16'd0, rhalf};
      default: load_fmt = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == WAIT_RESP && data_rdata_valid) begin
      load_data_r <= load_fmt;
    end
  end

  assign rf_wdata = mem_read ? load_data_r : alu_result;

  assign mem_to_wb_bus = {pc, rf_write & ~mem_write, rf_waddr, rf_wdata};

  assign mem_read_after_write_bus = {
    mem_valid && rf_write,
    !mem_read || state == HOLD,
    rf_waddr,
    rf_wdata
  };

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_stall_cnt  <= 32'd0;
      store_stall_cnt <= 32'd0;
    end else begin
      if (mem_valid && mem_read && !mem_write && !mem_ready_go) begin
        load_stall_cnt <= load_stall_cnt + 32'd1;
      end
      if (mem_valid && mem_write && !mem_ready_go) begin
        store_stall_cnt <= store_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage of the turbo RISC-V CPU; sits between ex_stage (upstream) and wb_stage (downstream).
- Issues loads/stores to the data-memory interface with a valid/ready request channel and a valid/ready response channel; aligns and sign-extends load data.
- Forwards {pc, rf_write, rf_waddr, rf_wdata} to wb_stage; exports a read-after-write bypass bus to id_stage.

Parameters:
- EX_BUS_WD, 107, width of ex_to_mem_bus: {pc[31:0], rf_write, rf_waddr[4:0], alu_result[31:0], mem_read, mem_write, funct3[2:0], store_data[31:0]}, MSB first.
- WB_BUS_WD, 70, width of mem_to_wb_bus: {pc[31:0], rf_write, rf_waddr[4:0], rf_wdata[31:0]}, MSB first.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ex_to_mem_valid  in  1  upstream instruction valid.
- ex_to_mem_bus  in  EX_BUS_WD  upstream payload.
- mem_allow_in  out  1  stage can accept an instruction this cycle.
- mem_to_wb_valid  out  1  result valid toward wb_stage.
- mem_to_wb_bus  out  WB_BUS_WD  result payload.
- wb_allow_in  in  1  wb_stage can accept.
- mem_read_after_write_bus  out  39  {write_valid, data_ready, rf_waddr[4:0], rf_wdata[31:0]}.
- data_req_valid  out  1  memory request valid.
- data_req_ready  in  1  memory accepts request.
- data_addr  out  32  word-aligned address {alu_result[31:2], 2'b00}.
- data_wen  out  1  1 = store, 0 = load.
- data_wstrb  out  4  byte enables (stores only; 0 for loads).
- data_wdata  out  32  replicated store data.
- data_rdata  in  32  load response word.
- data_rdata_valid  in  1  response valid.
- data_rdata_ready  out  1  stage accepts response.

Behaviour:
- Input register: mem_valid cleared on reset. When mem_allow_in, mem_valid <= ex_to_mem_valid. ex_to_mem_bus is latched only when ex_to_mem_valid && mem_allow_in.
- Handshake: mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in); mem_to_wb_valid = mem_valid && mem_ready_go.
- Non-memory instruction (mem_read = mem_write = 0): mem_ready_go = 1. No added latency; rf_wdata = alu_result.
- FSM states: IDLE, WAIT_RESP, HOLD. Reset -> IDLE.
  - IDLE: data_req_valid = mem_valid && (mem_read || mem_write). On data_req_ready, a store goes to HOLD and a load goes to WAIT_RESP.
  - WAIT_RESP: data_rdata_ready = 1. On data_rdata_valid, latch the formatted load data into load_data_r and go to HOLD.
  - HOLD: mem_ready_go = 1. Go to IDLE when wb_allow_in; a new instruction latched in the same cycle starts from IDLE next cycle.
- Exactly one request per memory instruction. Request outputs (data_req_valid, addr, wen, wstrb, wdata) are held stable while data_req_valid && !data_req_ready.
- Minimum latency with a zero-wait memory: store 1 cycle in IDLE + 1 in HOLD; load IDLE -> WAIT_RESP -> HOLD, 3 cycles.
- Store strobes (off = alu_result[1:0]):
  - SB (funct3 000): 4'b0001 << off.
  - SH (001): 4'b0011 << {off[1], 1'b0}.
  - SW (010): 4'b1111.
  - data_wdata replicates the byte or halfword across all lanes.
- Load formatting by funct3 and off:
  - LB 000 and LBU 100 take byte off.
  - LH 001 and LHU 101 take the halfword selected by off[1].
  - LW 010 takes the whole word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Misalignment is not checked; off[0] is ignored for halfwords.
- Store writeback: rf_write forced to 0 on mem_to_wb_bus.
- Bypass bus: write_valid = mem_valid && rf_write. data_ready = !mem_read || state == HOLD. rf_wdata is the alu_result or load_data_r.
- Reset mid-operation: state -> IDLE, mem_valid -> 0. A response arriving in IDLE or HOLD is ignored (data_rdata_ready = 0). The memory side shares the same reset.
- Output reset values:
  - 0 on reset: mem_to_wb_valid, data_req_valid, data_rdata_ready, write_valid.
  - 1 on reset: mem_allow_in.
  - Data outputs are don't-care while their valid is 0.

Optional Feature:
- MEM_STALL_CNT_EN: when defined, adds output ports load_stall_cnt[31:0] and store_stall_cnt[31:0].
  - Each counter increments by 1 on every cycle in which a load (resp. store) is in IDLE/WAIT_RESP with mem_ready_go = 0.
  - Cleared by reset; wraps from 0xFFFFFFFF to 0.
- When undefined, the ports and logic are absent.

Test Plan:
- ALU op, pc=0x80000000, rf_waddr=5, alu_result=0x1234, wb_allow_in=1 -> mem_to_wb_valid the cycle after latch; bus {0x80000000, 1, 5, 0x1234}; bypass data_ready=1.
- SB, alu_result=0x1003, store_data=0xAB, req_ready=1 -> data_addr=0x1000, wstrb=4'b1000, wdata=0xABABABAB; writeback rf_write=0.
- LB at off=2, data_rdata=0x00800000, response 3 cycles late -> rf_wdata=0xFFFFFF80. Bypass data_ready=0 until HOLD. LBU on the same data gives 0x00000080.
- Load with data_req_ready low for 4 cycles -> request signals stable; exactly one accepted request; mem_allow_in=0 throughout.
- Load completes while wb_allow_in=0 for 3 cycles -> stays in HOLD, payload stable. No second request; next instruction accepted the cycle wb_allow_in rises.
- Assert reset while in WAIT_RESP, then pulse data_rdata_valid -> state IDLE, mem_to_wb_valid=0, response ignored. With MEM_STALL_CNT_EN, counters read 0.
